nr_demux4_buf: RTL and testbench
================================

Name: nr_demux4_buf

Overview:
- Registered 1-to-4 demultiplexer for the nanoRisk 8-bit datapath; the inverse of the 4-input select mux.
- Steers one upstream byte stream to one of four downstream consumers, chosen by a 2-bit select.
- Each destination channel has a one-entry holding buffer with valid/ready handshakes on both sides.
- Sits between the ALU/register-file result bus and the output-port or peripheral write targets.

Parameters:
WIDTH, 8, data width in bits of input and of each output channel

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_data  input  WIDTH  upstream data byte
in_sel  input  2  destination channel index, 0..3
in_valid  input  1  upstream presents in_data/in_sel
in_ready  output  1  block accepts the current beat this cycle
out0_data  output  WIDTH  channel 0 buffered data
out1_data  output  WIDTH  channel 1 buffered data
out2_data  output  WIDTH  channel 2 buffered data
out3_data  output  WIDTH  channel 3 buffered data
out_valid  output  4  bit k set: channel k buffer holds an undelivered beat
out_ready  input  4  bit k set: consumer k takes its beat this cycle
busy  output  1  OR of out_valid
xfer_cnt  output  8  count of accepted input beats, modulo 256

Behaviour:
- Reset: when rst=1 at a clock edge, out_valid=4'b0000, all outN_data=0x00, xfer_cnt=0x00; busy follows as 0. Buffered beats are discarded, including mid-handshake. Reset overrides every same-cycle accept and drain.
- in_ready is combinational: (~out_valid[in_sel]) | out_ready[in_sel]. It depends only on the selected channel; full non-selected channels never stall input.
- Accept: in_valid & in_ready at an edge. Effects:
  - outS_data <= in_data and out_valid[S] <= 1, where S = in_sel;
  - xfer_cnt <= xfer_cnt + 1, wrapping 0xFF -> 0x00.
- Latency: out_valid[S] rises 1 cycle after acceptance. There is no combinational path from in_data to outN_data.
- Drain on channel k: out_valid[k] & out_ready[k] at an edge with no same-cycle accept to k. Then out_valid[k] <= 0 and outk_data keeps its last value; it is not cleared.
- Simultaneous accept and drain on the same channel: the old beat is delivered, the new beat is loaded, and out_valid[k] stays 1 (no bubble).
- Accept to channel S and drain of a different channel k in the same cycle are independent; both take effect.
- out_ready[k] while out_valid[k]=0 has no effect.
- Stability: while out_valid[k]=1 and out_ready[k]=0, outk_data and out_valid[k] hold.
- Upstream rule: in_data and in_sel stay stable while in_valid=1 and in_ready=0. The bench asserts this. The block's behaviour under a violation is to sample whatever is present at the accepting edge.
- Order: per channel, beats are delivered in acceptance order. There is no ordering guarantee across channels.
- busy is combinational from out_valid.
- Per-channel state machine, 2 states:
  - EMPTY -> FULL on accept;
  - FULL -> EMPTY on drain without accept;
  - FULL -> FULL on drain with accept, or on hold.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0 -> out_valid=0000, all data 0x00, xfer_cnt=0x00, busy=0, in_ready=1 for every in_sel.
- Routing: with out_ready=0000, send 0x11 to sel0, 0x22 to sel1, 0x33 to sel2, 0x44 to sel3 on consecutive cycles -> out_valid=1111; out0..3_data = 0x11/0x22/0x33/0x44; xfer_cnt=4; busy=1.
- Backpressure: channel 2 full with out_ready[2]=0, in_sel=2, in_valid=1, in_data=0x55 -> in_ready=0 and out2_data stays 0x33. Switch to in_sel=0 with channel 0 empty -> in_ready=1 and the beat is accepted.
- Pass-through: channel 1 holds 0xA0, out_ready[1]=1, in_sel=1, in_data=0xA1 in the same cycle -> 0xA0 delivered, next cycle out1_data=0xA1, out_valid[1]=1 throughout, in_ready=1.
- Counter wrap and drain: accept 256 beats round-robin with out_ready=1111 -> xfer_cnt returns to 0x00, every beat seen exactly once per channel in order, out_valid=0000 at end.
- Reset mid-operation: out_valid=1011, assert rst in the same cycle as an accept to channel 2 -> next cycle out_valid=0000, data=0x00, xfer_cnt=0x00, and the accepted beat is lost.

Source files
------------

// File: rtl/nr_demux4_buf.sv
// Registered 1-to-4 demultiplexer for the nanoRisk 8-bit datapath.
// Each destination has a one-entry valid/ready holding buffer; input is routed by in_sel.

module nr_demux4_buf_chan #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             valid
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state, state_next;

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // A load while full replaces the beat being drained, so no bubble appears.
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY:   if (load)           state_next = FULL;
            FULL:    if (drain && !load) state_next = EMPTY;
            default:                     state_next = EMPTY;
        endcase
    end

    // Data is left in place on drain; only a load or reset changes it.
    always_ff @(posedge clk) begin
        if (rst)       data <= '0;
        else if (load) data <= load_data;
    end

    assign valid = (state == FULL);
endmodule

module nr_demux4_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic [WIDTH-1:0] out3_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic             busy,
    output logic [7:0]       xfer_cnt
);
    logic [3:0][WIDTH-1:0] chan_data;
    logic [3:0]            load;
    logic                  accept;

    // Only the selected channel can stall the input.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < 4; k++) begin : g_chan
        assign load[k] = accept && (in_sel == 2'(k));

        nr_demux4_buf_chan #(.WIDTH(WIDTH)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .load      (load[k]),
            .drain     (out_ready[k]),
            .load_data (in_data),
            .data      (chan_data[k]),
            .valid     (out_valid[k])
        );
    end

    assign out0_data = chan_data[0];
    assign out1_data = chan_data[1];
    assign out2_data = chan_data[2];
    assign out3_data = chan_data[3];
    assign busy      = |out_valid;

    always_ff @(posedge clk) begin
        if (rst)         xfer_cnt <= 8'h00;
        else if (accept) xfer_cnt <= xfer_cnt + 8'h01;
    end
endmodule

// File: tb/tb_nr_demux4_buf.sv
// Bench for nr_demux4_buf: vector table for per-cycle state, plus a per-channel
// scoreboard that checks every delivered beat against acceptance order.

module tb_nr_demux4_buf;
    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0_data, out1_data, out2_data, out3_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       busy;
    logic [7:0] xfer_cnt;

    nr_demux4_buf #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0_data (out0_data),
        .out1_data (out1_data),
        .out2_data (out2_data),
        .out3_data (out3_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0][7:0] dat_all;
    assign dat_all = {out3_data, out2_data, out1_data, out0_data};

    typedef struct packed {
        logic        chk;
        logic        rst;
        logic        iv;
        logic [1:0]  sel;
        logic [7:0]  din;
        logic [3:0]  ordy;
        logic        ir;
        logic [3:0]  ov;
        logic [7:0]  cnt;
        logic        dchk;
        logic [31:0] dat;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [7:0] sbq [4][$];

    function automatic vec_t mk(logic c, logic r, logic iv, logic [1:0] s, logic [7:0] d,
                                logic [3:0] ordy, logic ir, logic [3:0] ov, logic [7:0] cnt,
                                logic dchk, logic [31:0] dat);
        vec_t v;
        v = '{chk:c, rst:r, iv:iv, sel:s, din:d, ordy:ordy, ir:ir, ov:ov, cnt:cnt,
              dchk:dchk, dat:dat};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Called just before the active edge: pop deliveries first, then push the accept,
    // so a same-cycle deliver/load on one channel keeps acceptance order.
    task automatic sb_update();
        logic [7:0] e;
        if (rst) begin
            for (int k = 0; k < 4; k++) sbq[k].delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (sbq[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_beat: channel %0d delivered %0h, expected nothing",
                                 k, dat_all[k]);
                    end else begin
                        e = sbq[k].pop_front();
                        chk($sformatf("sb_data_ch%0d", k), 32'(dat_all[k]), 32'(e));
                        pops++;
                    end
                end
            end
            if (in_valid && in_ready) sbq[in_sel].push_back(in_data);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [1:0] s,
                         input logic [7:0] d, input logic [3:0] ordy);
        rst       = r;
        in_valid  = iv;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
    endtask

    // Upstream must hold data/sel while a beat is stalled.
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data;
    logic [1:0] prev_sel;
    always @(negedge clk) begin
        if (prev_hold && in_valid)
            assert (in_data == prev_data && in_sel == prev_sel)
            else $error("FAIL upstream_stable: data %0h sel %0d, held %0h sel %0d",
                        in_data, in_sel, prev_data, prev_sel);
        prev_hold <= in_valid && !in_ready && !rst;
        prev_data <= in_data;
        prev_sel  <= in_sel;
    end

    initial begin
        // pre-edge state for each cycle: {chk,rst,iv,sel,din,ordy, ir,ov,cnt, dchk,dat}
        vecs[0]  = mk(0,1,0,0,8'h00,4'b0000, 1,4'b0000,8'd0, 0,32'h0);
        vecs[1]  = mk(1,1,0,0,8'h00,4'b0000, 1,4'b0000,8'd0, 1,32'h00000000);
        vecs[2]  = mk(1,0,0,1,8'h00,4'b0000, 1,4'b0000,8'd0, 0,32'h0);
        vecs[3]  = mk(1,0,0,2,8'h00,4'b0000, 1,4'b0000,8'd0, 0,32'h0);
        vecs[4]  = mk(1,0,0,3,8'h00,4'b0000, 1,4'b0000,8'd0, 0,32'h0);
        vecs[5]  = mk(1,0,1,0,8'h11,4'b0000, 1,4'b0000,8'd0, 0,32'h0);
        vecs[6]  = mk(1,0,1,1,8'h22,4'b0000, 1,4'b0001,8'd1, 0,32'h0);
        vecs[7]  = mk(1,0,1,2,8'h33,4'b0000, 1,4'b0011,8'd2, 0,32'h0);
        vecs[8]  = mk(1,0,1,3,8'h44,4'b0000, 1,4'b0111,8'd3, 0,32'h0);
        vecs[9]  = mk(1,0,0,0,8'h00,4'b0000, 0,4'b1111,8'd4, 1,32'h44332211);
        vecs[10] = mk(1,0,1,2,8'h55,4'b0000, 0,4'b1111,8'd4, 0,32'h0);
        vecs[11] = mk(1,0,1,2,8'h55,4'b0000, 0,4'b1111,8'd4, 1,32'h44332211);
        vecs[12] = mk(1,0,0,0,8'h00,4'b0001, 1,4'b1111,8'd4, 0,32'h0);
        vecs[13] = mk(1,0,1,0,8'h66,4'b0000, 1,4'b1110,8'd4, 0,32'h0);
        vecs[14] = mk(1,0,0,0,8'h00,4'b0000, 0,4'b1111,8'd5, 1,32'h44332266);
        vecs[15] = mk(1,0,1,1,8'hA0,4'b0010, 1,4'b1111,8'd5, 0,32'h0);
        vecs[16] = mk(1,0,1,1,8'hA1,4'b0010, 1,4'b1111,8'd6, 1,32'h4433A066);
        vecs[17] = mk(1,0,0,0,8'h00,4'b0000, 0,4'b1111,8'd7, 1,32'h4433A166);
        vecs[18] = mk(1,0,0,0,8'h00,4'b1111, 1,4'b1111,8'd7, 0,32'h0);
        vecs[19] = mk(1,0,0,0,8'h00,4'b0000, 1,4'b0000,8'd7, 1,32'h4433A166);
        vecs[20] = mk(1,0,1,3,8'h77,4'b0000, 1,4'b0000,8'd7, 0,32'h0);
        vecs[21] = mk(1,0,1,2,8'h88,4'b1000, 1,4'b1000,8'd8, 0,32'h0);
        vecs[22] = mk(1,0,0,0,8'h00,4'b0000, 1,4'b0100,8'd9, 1,32'h7788A166);
        vecs[23] = mk(1,0,0,0,8'h00,4'b1011, 1,4'b0100,8'd9, 0,32'h0);
        vecs[24] = mk(1,0,0,2,8'h00,4'b0000, 0,4'b0100,8'd9, 0,32'h0);
        vecs[25] = mk(1,0,1,0,8'hB0,4'b0100, 1,4'b0100,8'd9, 0,32'h0);
        vecs[26] = mk(1,0,1,1,8'hB1,4'b0000, 1,4'b0001,8'd10,0,32'h0);
        vecs[27] = mk(1,0,1,3,8'hB3,4'b0000, 1,4'b0011,8'd11,0,32'h0);
        vecs[28] = mk(1,1,1,2,8'hB2,4'b0000, 1,4'b1011,8'd12,1,32'hB388B1B0);
        vecs[29] = mk(1,0,0,0,8'h00,4'b0000, 1,4'b0000,8'd0, 1,32'h00000000);

        drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000);
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].sel, vecs[i].din, vecs[i].ordy);
            @(negedge clk);
            if (vecs[i].chk) begin
                chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
                chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
                chk($sformatf("v%0d_busy", i), 32'(busy), 32'(|vecs[i].ov));
                chk($sformatf("v%0d_xfer_cnt", i), 32'(xfer_cnt), 32'(vecs[i].cnt));
                if (vecs[i].dchk)
                    chk($sformatf("v%0d_data", i), dat_all, vecs[i].dat);
            end
            sb_update();
            @(posedge clk); #1;
        end

        // 256 round-robin beats with all consumers ready: counter wraps, queues drain.
        pops = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ib;
            ib = 8'(i);
            drive(1'b0, 1'b1, ib[1:0], ib ^ 8'h5A, 4'b1111);
            @(negedge clk);
            chk("wrap_in_ready", 32'(in_ready), 32'd1);
            if (i == 255) chk("wrap_cnt_ff", 32'(xfer_cnt), 32'hFF);
            sb_update();
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
        @(negedge clk);
        sb_update();
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
        @(negedge clk);
        chk("wrap_xfer_cnt", 32'(xfer_cnt), 32'h00);
        chk("wrap_out_valid", 32'(out_valid), 32'h0);
        chk("wrap_busy", 32'(busy), 32'd0);
        chk("wrap_pops", 32'(pops), 32'd256);
        chk("wrap_leftover", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
